mux4_tdm_gatherer: RTL and testbench

- Sequential 4-to-1 gatherer: merges four valid/ready input channels onto one registered output stream.
- Arbitration is round-robin.
- Each output word carries a 2-bit channel tag on sel_a/sel_b.
- It is the transmit end of the 1-to-4 demux path: the downstream demux routes `out` back to o0..o3 using sel_a (MSB) and sel_b (LSB).

---
 rtl/mux4_tdm_gatherer.sv | 128 ++++++++++++
 tb/tb_mux4_tdm_gatherer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux4_tdm_gatherer.sv
// mux4_tdm_gatherer: merges four valid/ready channels onto one registered,
// channel-tagged output stream ({sel_a,sel_b} = source channel).
// Arbitration is round-robin by default; define MUX4_FIXED_PRIO_EN for
// fixed priority ch0 > ch1 > ch2 > ch3 (the round-robin pointer is removed).
module mux4_tdm_gatherer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             v0,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  output logic             rdy0,
  output logic             rdy1,
  output logic             rdy2,
  output logic             rdy3,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel_a,
  output logic             sel_b
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       v_vec;
  logic [3:0]       rdy_vec;
  logic             load_en;
  logic             grant_found;
  logic [1:0]       grant;
  logic             xfer;
  logic [WIDTH-1:0] in_g;
`ifndef MUX4_FIXED_PRIO_EN
  logic [1:0]       ptr;
`endif

  assign v_vec = {v3, v2, v1, v0};
  assign {rdy3, rdy2, rdy1, rdy0} = rdy_vec;
  assign out_valid = (state == FULL);

  // Arbitration: first valid channel in search order.
`ifdef MUX4_FIXED_PRIO_EN
  always_comb begin
    grant_found = 1'b0;
    grant       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v_vec[i]) begin
        grant_found = 1'b1;
        grant       = 2'(i);
      end
    end
  end
`else
  always_comb begin
    logic [1:0] cand;
    grant_found = 1'b0;
    grant       = 2'd0;
    cand        = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!grant_found && v_vec[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end
`endif

  // Data mux for the granted channel.
  always_comb begin
    in_g = in0;
    case (grant)
      2'd0:    in_g = in0;
      2'd1:    in_g = in1;
      2'd2:    in_g = in2;
      default: in_g = in3;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next state, load enable and single-hot ready (suppressed during reset).
  always_comb begin
    state_nxt = state;
    rdy_vec   = 4'b0000;
    load_en   = (state == EMPTY) || out_ready;
    xfer      = load_en && grant_found;
    if (xfer && !rst) rdy_vec = 4'b0001 << grant;
    case (state)
      EMPTY: if (grant_found) state_nxt = FULL;
      FULL:  if (out_ready) state_nxt = grant_found ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output word, tag and pointer; update only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= '0;
      sel_a <= 1'b0;
      sel_b <= 1'b0;
`ifndef MUX4_FIXED_PRIO_EN
      ptr   <= 2'd0;
`endif
    end else if (xfer) begin
      out            <= in_g;
      {sel_a, sel_b} <= grant;
`ifndef MUX4_FIXED_PRIO_EN
      ptr            <= grant + 2'd1;
`endif
    end
  end

endmodule

// File: tb/tb_mux4_tdm_gatherer.sv
// Testbench for mux4_tdm_gatherer: reference arbitration model feeds a
// scoreboard queue of {tag,data}; DUT output is compared each cycle.
module tb_mux4_tdm_gatherer;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic             v0, v1, v2, v3;
  logic             rdy0, rdy1, rdy2, rdy3;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             sel_a, sel_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [9:0] sb[$];
  logic [9:0] m_last;
  logic [1:0] m_ptr;
  logic       m_full;

  mux4_tdm_gatherer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .rdy0(rdy0), .rdy1(rdy1), .rdy2(rdy2), .rdy3(rdy3),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .sel_a(sel_a), .sel_b(sel_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void arb(input logic [3:0] v, input logic [1:0] p,
                              output logic f, output logic [1:0] g);
    logic [1:0] c;
    f = 1'b0;
    g = 2'd0;
`ifdef MUX4_FIXED_PRIO_EN
    c = p;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) begin f = 1'b1; g = 2'(i); end
    end
`else
    for (int i = 0; i < 4; i++) begin
      c = p + 2'(i);
      if (!f && v[c]) begin f = 1'b1; g = c; end
    end
`endif
  endfunction

  function automatic logic [7:0] data_of(input logic [1:0] g);
    case (g)
      2'd0:    return in0;
      2'd1:    return in1;
      2'd2:    return in2;
      default: return in3;
    endcase
  endfunction

  task automatic model_reset();
    sb.delete();
    m_last = '0;
    m_ptr  = 2'd0;
    m_full = 1'b0;
  endtask

  // One clock: check ready before the edge, update model at the edge, check outputs after.
  task automatic cycle();
    logic       le, f;
    logic [1:0] g;
    logic [3:0] exp_rdy;
    logic [9:0] dummy;
    @(negedge clk);
    le = !m_full || out_ready;
    arb({v3, v2, v1, v0}, m_ptr, f, g);
    exp_rdy = (le && f) ? (4'b0001 << g) : 4'b0000;
    check("rdy", 32'({rdy3, rdy2, rdy1, rdy0}), 32'(exp_rdy));
    @(posedge clk);
    if (m_full && out_ready && sb.size() > 0) dummy = sb.pop_front();
    if (le) begin
      if (f) begin
        sb.push_back({g, data_of(g)});
        m_last = {g, data_of(g)};
        m_ptr  = g + 2'd1;
        m_full = 1'b1;
      end else begin
        m_full = 1'b0;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full && sb.size() > 0) check("word", 32'({sel_a, sel_b, out}), 32'(sb[0]));
    else check("hold", 32'({sel_a, sel_b, out}), 32'(m_last));
  endtask

  task automatic set_v(input logic [3:0] v);
    {v3, v2, v1, v0} = v;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    in0 = 8'h10; in1 = 8'h21; in2 = 8'h32; in3 = 8'h43;
    set_v(4'b1111);
    model_reset();

    // Reset held with all channels valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_word", 32'({sel_a, sel_b, out}), 32'd0);
    check("rst_rdy", 32'({rdy3, rdy2, rdy1, rdy0}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifndef MUX4_FIXED_PRIO_EN
    // Round-robin over four valid channels.
    repeat (6) cycle();
    check("rr_word6", 32'({sel_a, sel_b, out}), 32'({2'b01, 8'h21}));

    // Backpressure holds word and tag, ready stays low.
    out_ready = 1'b0;
    repeat (5) cycle();
    check("bp_hold", 32'({sel_a, sel_b, out}), 32'({2'b01, 8'h21}));
    out_ready = 1'b1;
    cycle();
    check("bp_next", 32'({sel_a, sel_b, out}), 32'({2'b10, 8'h32}));

    // Sparse traffic with pointer wrap.
    set_v(4'b0000);
    cycle();
    in3 = 8'hA5; set_v(4'b1000);
    cycle();
    check("sparse_a5", 32'({sel_a, sel_b, out}), 32'({2'b11, 8'hA5}));
    in0 = 8'h5A; set_v(4'b0001);
    cycle();
    check("sparse_5a", 32'({sel_a, sel_b, out}), 32'({2'b00, 8'h5A}));
    set_v(4'b0000);
    cycle();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Async reset between edges while a word is pending.
    in0 = 8'h10; in3 = 8'h43; set_v(4'b1111);
    for (int i = 0; i < 8 && !(m_full && m_ptr == 2'd2); i++) cycle();
    check("pre_rst_ptr", 32'(m_ptr), 32'd2);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_rdy", 32'({rdy3, rdy2, rdy1, rdy0}), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    cycle();
    check("post_rst_ch0", 32'({sel_a, sel_b, out}), 32'({2'b00, 8'h10}));
`else
    // Fixed priority: ch0 starves ch1 until it drops valid.
    set_v(4'b0011);
    repeat (4) cycle();
    check("fp_ch0", 32'({sel_a, sel_b, out}), 32'({2'b00, 8'h10}));
    set_v(4'b0010);
    cycle();
    check("fp_ch1", 32'({sel_a, sel_b, out}), 32'({2'b01, 8'h21}));
`endif

    // Random valid/ready traffic against the model.
    for (int i = 0; i < 60; i++) begin
      set_v(4'($urandom_range(0, 15)));
      in0 = 8'($urandom); in1 = 8'($urandom);
      in2 = 8'($urandom); in3 = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
